// File: rtl/axi_redirect_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// axi_redirect_cfg_ctrl
//
// Purpose: reprograms the AW decoder redirect (source_r / target_r /
// redirect_valid_r) at runtime without corrupting traffic in flight. On a
// request the AW path is closed at a legal AXI boundary, outstanding writes
// are drained, and the new mapping is applied atomically before the path
// reopens.
//
// State table:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for cfg_req_i; request is checked and latched here
//   S_HOLD  | waiting for an AW boundary (no valid-without-ready pending)
//   S_DRAIN | AW held; waiting for outstanding writes to finish (timed)
//   S_APPLY | AW held; applied redirect registers load latched request
//   S_RESP  | one-cycle done/err pulse, then back to idle
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_req_i                level request, held until cfg_done_o
//   cfg_enable_i             1 = install redirect, 0 = remove it
//   cfg_source_i/target_i    requested redirect source / target port
//   cfg_done_o, cfg_err_o    completion pulse and its error qualifier
//   awvalid_i, awready_i     AW handshake observed at the decoder
//   aw_hold_o                forces upstream AW valid low
//   outstanding_trans_i      writes still pending downstream
//   source_r_o, target_r_o,
//   redirect_valid_r_o       applied redirect, to the decoder
//   busy_o                   controller not idle
// ---------------------------------------------------------------------------
module axi_redirect_cfg_ctrl #(
  parameter int N_INIT_PORT    = 8,
  parameter int LOG_N_INIT     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_req_i,
  input  logic                  cfg_enable_i,
  input  logic [LOG_N_INIT-1:0] cfg_source_i,
  input  logic [LOG_N_INIT-1:0] cfg_target_i,
  output logic                  cfg_done_o,
  output logic                  cfg_err_o,
  input  logic                  awvalid_i,
  input  logic                  awready_i,
  output logic                  aw_hold_o,
  input  logic                  outstanding_trans_i,
  output logic [LOG_N_INIT-1:0] source_r_o,
  output logic [LOG_N_INIT-1:0] target_r_o,
  output logic                  redirect_valid_r_o,
  output logic                  busy_o
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_DRAIN,
    S_APPLY,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  en_q, en_d;
  logic [LOG_N_INIT-1:0] src_q, src_d;
  logic [LOG_N_INIT-1:0] tgt_q, tgt_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOG_N_INIT-1:0] src_r_q, src_r_d;
  logic [LOG_N_INIT-1:0] tgt_r_q, tgt_r_d;
  logic                  valid_r_q, valid_r_d;
  logic                  hold_q, hold_d;
  logic                  req_bad;
  logic                  aw_pending;

  // Only an install can be malformed; a removal ignores source/target.
  assign req_bad = cfg_enable_i &&
                   ((int'(cfg_source_i) >= N_INIT_PORT) ||
                    (int'(cfg_target_i) >= N_INIT_PORT) ||
                    (cfg_source_i == cfg_target_i));

  // Valid without ready means an AW beat is mid-handshake; dropping valid
  // now would violate AXI, so the hold may not rise.
  assign aw_pending = awvalid_i & ~awready_i;

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    src_d     = src_q;
    tgt_d     = tgt_q;
    err_d     = err_q;
    cnt_d     = '0;
    src_r_d   = src_r_q;
    tgt_r_d   = tgt_r_q;
    valid_r_d = valid_r_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_req_i) begin
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            en_d    = cfg_enable_i;
            src_d   = cfg_source_i;
            tgt_d   = cfg_target_i;
            err_d   = 1'b0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!aw_pending) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A drained downstream wins over a timeout in the same cycle.
        if (!outstanding_trans_i) begin
          state_d = S_APPLY;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_APPLY: begin
        valid_r_d = en_q;
        // A removal leaves the last source/target in place.
        if (en_q) begin
          src_r_d = src_q;
          tgt_r_d = tgt_q;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Hold is registered from the next state; in RESP it stays up only after
  // an apply so the decoder sees the new map before traffic resumes.
  always_comb begin
    hold_d = (state_d == S_DRAIN) || (state_d == S_APPLY) ||
             ((state_d == S_RESP) && (state_q == S_APPLY));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      src_q     <= '0;
      tgt_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      src_r_q   <= '0;
      tgt_r_q   <= '0;
      valid_r_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      src_q     <= src_d;
      tgt_q     <= tgt_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      src_r_q   <= src_r_d;
      tgt_r_q   <= tgt_r_d;
      valid_r_q <= valid_r_d;
      hold_q    <= hold_d;
    end
  end

  assign cfg_done_o         = (state_q == S_RESP);
  assign cfg_err_o          = (state_q == S_RESP) & err_q;
  assign busy_o             = (state_q != S_IDLE);
  assign aw_hold_o          = hold_q;
  assign source_r_o         = src_r_q;
  assign target_r_o         = tgt_r_q;
  assign redirect_valid_r_o = valid_r_q;

endmodule

// File: tb/tb_axi_redirect_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_redirect_cfg_ctrl
//
// Directed bench. Instance a: default parameters (8 ports, 3-bit index,
// 1024-cycle timeout). Instance b: 8 ports with a 4-bit index, so an
// out-of-range target of 8 can be presented, and an 8-cycle timeout.
// Both share reset, enable, AW handshake and outstanding; each has its
// own request, source and target.
// ---------------------------------------------------------------------------
module tb_axi_redirect_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_enable;
  logic       awvalid, awready, outstanding;

  logic       req_a;
  logic [2:0] src_a, tgt_a;
  logic       done_a, err_a, hold_a, valid_a, busy_a;
  logic [2:0] src_r_a, tgt_r_a;

  logic       req_b;
  logic [3:0] src_b, tgt_b;
  logic       done_b, err_b, hold_b, valid_b, busy_b;
  logic [3:0] src_r_b, tgt_r_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_redirect_cfg_ctrl #(
    .N_INIT_PORT(8), .LOG_N_INIT(3), .TIMEOUT_CYCLES(1024)
  ) dut_a (
    .clk(clk), .rst(rst),
    .cfg_req_i(req_a), .cfg_enable_i(cfg_enable),
    .cfg_source_i(src_a), .cfg_target_i(tgt_a),
    .cfg_done_o(done_a), .cfg_err_o(err_a),
    .awvalid_i(awvalid), .awready_i(awready), .aw_hold_o(hold_a),
    .outstanding_trans_i(outstanding),
    .source_r_o(src_r_a), .target_r_o(tgt_r_a),
    .redirect_valid_r_o(valid_a), .busy_o(busy_a)
  );

  axi_redirect_cfg_ctrl #(
    .N_INIT_PORT(8), .LOG_N_INIT(4), .TIMEOUT_CYCLES(8)
  ) dut_b (
    .clk(clk), .rst(rst),
    .cfg_req_i(req_b), .cfg_enable_i(cfg_enable),
    .cfg_source_i(src_b), .cfg_target_i(tgt_b),
    .cfg_done_o(done_b), .cfg_err_o(err_b),
    .awvalid_i(awvalid), .awready_i(awready), .aw_hold_o(hold_b),
    .outstanding_trans_i(outstanding),
    .source_r_o(src_r_b), .target_r_o(tgt_r_b),
    .redirect_valid_r_o(valid_b), .busy_o(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in idle with a request already driven: run until done, report
  // cycles to done (the sampling edge is cycle 1), cycles with hold high
  // (including the done cycle) and err at done.
  task automatic wait_done(input bit sel, input int max_cyc,
                           output int cyc, output int holds, output logic err);
    logic seen;
    seen  = 1'b0;
    cyc   = 0;
    holds = 0;
    err   = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      cyc++;
      if (sel ? hold_b : hold_a) holds++;
      if (sel ? done_b : done_a) begin
        err  = sel ? err_b : err_a;
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  int   cyc, holds, hacc;
  logic err;

  initial begin
    rst = 1'b1; cfg_enable = 1'b0; awvalid = 1'b0; awready = 1'b0;
    outstanding = 1'b0;
    req_a = 1'b0; src_a = '0; tgt_a = '0;
    req_b = 1'b0; src_b = '0; tgt_b = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_hold",  32'(hold_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_src",   32'(src_r_a), 32'd0);
    chk("rst_tgt",   32'(tgt_r_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);

    // Valid install, idle bus, nothing outstanding
    req_a = 1'b1; cfg_enable = 1'b1; src_a = 3'd2; tgt_a = 3'd5;
    wait_done(1'b0, 20, cyc, holds, err);
    chk("inst_lat",   32'(cyc),     32'd4);
    chk("inst_holds", 32'(holds),   32'd3);
    chk("inst_err",   32'(err),     32'd0);
    chk("inst_src",   32'(src_r_a), 32'd2);
    chk("inst_tgt",   32'(tgt_r_a), 32'd5);
    chk("inst_valid", 32'(valid_a), 32'd1);
    req_a = 1'b0;
    tick();
    chk("inst_idle_busy", 32'(busy_a), 32'd0);
    chk("inst_idle_hold", 32'(hold_a), 32'd0);
    chk("inst_idle_done", 32'(done_a), 32'd0);

    // Boundary: AW stalled mid-handshake while in HOLD
    req_a = 1'b1; src_a = 3'd1; tgt_a = 3'd6; awvalid = 1'b1; awready = 1'b0;
    tick();
    chk("bnd_busy", 32'(busy_a), 32'd1);
    hacc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (hold_a) hacc++;
    end
    chk("bnd_hold_low", 32'(hacc), 32'd0);
    awready = 1'b1;
    tick();
    chk("bnd_hold_rise", 32'(hold_a), 32'd1);
    awvalid = 1'b0; awready = 1'b0;
    tick();
    tick();
    chk("bnd_done", 32'(done_a),  32'd1);
    chk("bnd_err",  32'(err_a),   32'd0);
    chk("bnd_src",  32'(src_r_a), 32'd1);
    chk("bnd_tgt",  32'(tgt_r_a), 32'd6);
    req_a = 1'b0;
    tick();

    // Drain wait: 20 DRAIN cycles with writes outstanding
    req_a = 1'b1; src_a = 3'd0; tgt_a = 3'd7; outstanding = 1'b1;
    tick();
    tick();
    chk("drn_hold0", 32'(hold_a), 32'd1);
    hacc = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (done_a || !hold_a) hacc++;
    end
    chk("drn_stayed", 32'(hacc), 32'd0);
    outstanding = 1'b0;
    tick();
    chk("drn_apply_nodone", 32'(done_a), 32'd0);
    tick();
    chk("drn_done",  32'(done_a),  32'd1);
    chk("drn_err",   32'(err_a),   32'd0);
    chk("drn_src",   32'(src_r_a), 32'd0);
    chk("drn_tgt",   32'(tgt_r_a), 32'd7);
    chk("drn_valid", 32'(valid_a), 32'd1);
    req_a = 1'b0;
    tick();

    // Remove: equal source/target is fine when disabling
    req_a = 1'b1; cfg_enable = 1'b0; src_a = 3'd4; tgt_a = 3'd4;
    wait_done(1'b0, 20, cyc, holds, err);
    chk("rm_lat",   32'(cyc),     32'd4);
    chk("rm_err",   32'(err),     32'd0);
    chk("rm_valid", 32'(valid_a), 32'd0);
    chk("rm_src",   32'(src_r_a), 32'd0);
    chk("rm_tgt",   32'(tgt_r_a), 32'd7);
    req_a = 1'b0;
    tick();

    // Reject: source == target
    req_a = 1'b1; cfg_enable = 1'b1; src_a = 3'd3; tgt_a = 3'd3;
    wait_done(1'b0, 20, cyc, holds, err);
    chk("rej_eq_lat",   32'(cyc),     32'd1);
    chk("rej_eq_err",   32'(err),     32'd1);
    chk("rej_eq_holds", 32'(holds),   32'd0);
    chk("rej_eq_src",   32'(src_r_a), 32'd0);
    chk("rej_eq_tgt",   32'(tgt_r_a), 32'd7);
    req_a = 1'b0;
    tick();
    chk("rej_eq_idle", 32'(busy_a), 32'd0);

    // Instance b: install a baseline map
    req_b = 1'b1; cfg_enable = 1'b1; src_b = 4'd1; tgt_b = 4'd2;
    wait_done(1'b1, 20, cyc, holds, err);
    chk("b_inst_lat",   32'(cyc),     32'd4);
    chk("b_inst_valid", 32'(valid_b), 32'd1);
    req_b = 1'b0;
    tick();

    // Timeout: outstanding stuck high, 8 DRAIN cycles then done+err
    req_b = 1'b1; src_b = 4'd3; tgt_b = 4'd4; outstanding = 1'b1;
    wait_done(1'b1, 40, cyc, holds, err);
    chk("to_lat",   32'(cyc),     32'd10);
    chk("to_err",   32'(err),     32'd1);
    chk("to_holds", 32'(holds),   32'd8);
    chk("to_hold",  32'(hold_b),  32'd0);
    chk("to_src",   32'(src_r_b), 32'd1);
    chk("to_tgt",   32'(tgt_r_b), 32'd2);
    chk("to_valid", 32'(valid_b), 32'd1);
    req_b = 1'b0; outstanding = 1'b0;
    tick();

    // Reject: target out of range
    req_b = 1'b1; src_b = 4'd1; tgt_b = 4'd8;
    wait_done(1'b1, 20, cyc, holds, err);
    chk("rej_rng_lat",   32'(cyc),   32'd1);
    chk("rej_rng_err",   32'(err),   32'd1);
    chk("rej_rng_holds", 32'(holds), 32'd0);
    chk("rej_rng_tgt",   32'(tgt_r_b), 32'd2);
    req_b = 1'b0;
    tick();

    // Reset in the middle of DRAIN
    req_a = 1'b1; cfg_enable = 1'b1; src_a = 3'd5; tgt_a = 3'd6; outstanding = 1'b1;
    tick();
    tick();
    chk("mid_busy", 32'(busy_a), 32'd1);
    chk("mid_hold", 32'(hold_a), 32'd1);
    rst = 1'b1; req_a = 1'b0;
    tick();
    chk("mrst_busy",    32'(busy_a),  32'd0);
    chk("mrst_hold",    32'(hold_a),  32'd0);
    chk("mrst_done",    32'(done_a),  32'd0);
    chk("mrst_src",     32'(src_r_a), 32'd0);
    chk("mrst_tgt",     32'(tgt_r_a), 32'd0);
    chk("mrst_valid",   32'(valid_a), 32'd0);
    chk("mrst_b_valid", 32'(valid_b), 32'd0);
    rst = 1'b0; outstanding = 1'b0;
    hacc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_a || busy_a) hacc++;
    end
    chk("mrst_quiet", 32'(hacc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
